// File: rtl/lane_scan_capture.sv
// lane_scan_capture: samples one upstream lane flag per cycle, starting at START_LANE and wrapping,
// then hands the assembled word downstream over valid/ready. LANE_SCAN_CAPTURE_PARITY_EN adds out_parity.
module lane_scan_capture #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned START_LANE = 2,
    localparam int unsigned IDXW      = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] lane_y,
    input  logic                 start,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_LANES-1:0] out_word,
    output logic [IDXW-1:0]      out_first_lane,
    output logic [7:0]           drop_cnt
`ifdef LANE_SCAN_CAPTURE_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    typedef enum logic [1:0] {StIdle, StScan, StValid} state_e;

    localparam logic [IDXW-1:0] StartIdx = IDXW'(START_LANE);
    localparam logic [IDXW-1:0] LastIdx  = IDXW'(NUM_LANES - 1);

    if (START_LANE >= NUM_LANES || NUM_LANES < 2) begin : gen_param_check
        $error("lane_scan_capture: need NUM_LANES >= 2 and START_LANE < NUM_LANES");
    end

    state_e               state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [IDXW-1:0]      cnt_q, cnt_d;
    logic [NUM_LANES-1:0] word_q, word_d;
    logic [7:0]           drop_q, drop_d;
    logic                 drop_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= StartIdx;
            cnt_q   <= '0;
            word_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        drop_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    idx_d   = StartIdx;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            StScan: begin
                word_d[cnt_q] = lane_y[idx_q];
                // Explicit compare keeps the wrap correct for non-power-of-two lane counts.
                idx_d    = (idx_q == LastIdx) ? '0 : idx_q + IDXW'(1);
                cnt_d    = cnt_q + IDXW'(1);
                drop_req = start;
                if (cnt_q == LastIdx) begin
                    state_d = StValid;
                end
            end
            StValid: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = StScan;
                        idx_d   = StartIdx;
                        cnt_d   = '0;
                        word_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    drop_req = start;
                end
            end
            default: state_d = StIdle;
        endcase
        drop_d = (drop_req && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    end

`ifdef LANE_SCAN_CAPTURE_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^word_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign busy           = (state_q != StIdle);
    assign out_valid      = (state_q == StValid);
    assign out_word       = word_q;
    assign out_first_lane = StartIdx;
    assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_lane_scan_capture.sv
// Self-checking bench for lane_scan_capture: a 4-lane and a 3-lane instance, both starting at lane 2,
// driven with directed and $urandom lane patterns against a per-capture-edge reference model.
module tb_lane_scan_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lane_y;
    logic       start;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_word;
    logic [1:0] out_first_lane;
    logic [7:0] drop_cnt;
    logic [2:0] lane_y3;
    logic       start3;
    logic       busy3;
    logic       out_valid3;
    logic       out_ready3;
    logic [2:0] out_word3;
    logic [1:0] out_first_lane3;
    logic [7:0] drop_cnt3;
`ifdef LANE_SCAN_CAPTURE_PARITY_EN
    logic       out_parity;
    logic       out_parity3;
`endif

    int         nchk = 0;
    int         nfail = 0;
    int         exp_drop = 0;
    int         exp_drop3 = 0;
    logic [3:0] yseq [4];
    logic [3:0] w;

    always #5 clk = ~clk;

    lane_scan_capture #(.NUM_LANES(4), .START_LANE(2)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .lane_y         (lane_y),
        .start          (start),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_word       (out_word),
        .out_first_lane (out_first_lane),
        .drop_cnt       (drop_cnt)
`ifdef LANE_SCAN_CAPTURE_PARITY_EN
        ,
        .out_parity     (out_parity)
`endif
    );

    lane_scan_capture #(.NUM_LANES(3), .START_LANE(2)) u_dut3 (
        .clk            (clk),
        .rst            (rst),
        .lane_y         (lane_y3),
        .start          (start3),
        .busy           (busy3),
        .out_valid      (out_valid3),
        .out_ready      (out_ready3),
        .out_word       (out_word3),
        .out_first_lane (out_first_lane3),
        .drop_cnt       (drop_cnt3)
`ifdef LANE_SCAN_CAPTURE_PARITY_EN
        ,
        .out_parity     (out_parity3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input string what, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Runs one scan from IDLE (or from an already-accepted start); the expected word is built from the
    // lane value present at each capture edge, lane (2 + k) mod n for bit k.
    task automatic scan(input bit odd, input bit started, input bit drops, input string tag,
                        output logic [3:0] expw);
        int n;
        n = odd ? 3 : 4;
        expw = '0;
        if (!started) begin
            if (odd) start3 = 1'b1;
            else start = 1'b1;
            tick();
            start = 1'b0;
            start3 = 1'b0;
        end
        check(tag, "busy", odd ? 32'(busy3) : 32'(busy), 32'd1);
        check(tag, "word_cleared", odd ? 32'(out_word3) : 32'(out_word), 32'd0);
        for (int k = 0; k < n; k++) begin
            int lane;
            lane = (2 + k) % n;
            if (odd) lane_y3 = yseq[k][2:0];
            else lane_y = yseq[k];
            expw[k] = yseq[k][lane];
            if (drops && $urandom_range(0, 1) == 1) begin
                if (odd) begin
                    start3 = 1'b1;
                    exp_drop3 = sat(exp_drop3 + 1);
                end else begin
                    start = 1'b1;
                    exp_drop = sat(exp_drop + 1);
                end
            end
            check(tag, "valid_early", odd ? 32'(out_valid3) : 32'(out_valid), 32'd0);
            tick();
            start = 1'b0;
            start3 = 1'b0;
        end
        check(tag, "valid", odd ? 32'(out_valid3) : 32'(out_valid), 32'd1);
        check(tag, "word", odd ? 32'(out_word3) : 32'(out_word), 32'(expw));
        check(tag, "first_lane", odd ? 32'(out_first_lane3) : 32'(out_first_lane), 32'd2);
        check(tag, "drop_cnt", odd ? 32'(drop_cnt3) : 32'(drop_cnt),
              odd ? 32'(exp_drop3) : 32'(exp_drop));
`ifdef LANE_SCAN_CAPTURE_PARITY_EN
        check(tag, "parity", odd ? 32'(out_parity3) : 32'(out_parity), 32'(^expw));
`endif
    endtask

    task automatic handshake(input bit odd, input int wait_cyc, input logic [3:0] expw,
                             input string tag);
        for (int c = 0; c < wait_cyc; c++) begin
            tick();
            check(tag, "hold_valid", odd ? 32'(out_valid3) : 32'(out_valid), 32'd1);
            check(tag, "hold_word", odd ? 32'(out_word3) : 32'(out_word), 32'(expw));
        end
        if (odd) out_ready3 = 1'b1;
        else out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        out_ready3 = 1'b0;
        check(tag, "valid_after_hs", odd ? 32'(out_valid3) : 32'(out_valid), 32'd0);
        check(tag, "busy_after_hs", odd ? 32'(busy3) : 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start3 = 1'b0;
        lane_y = '0;
        lane_y3 = '0;
        out_ready = 1'b0;
        out_ready3 = 1'b0;
        tick();
        tick();
        check("reset", "busy", 32'(busy), 32'd0);
        check("reset", "valid", 32'(out_valid), 32'd0);
        check("reset", "word", 32'(out_word), 32'd0);
        check("reset", "drop_cnt", 32'(drop_cnt), 32'd0);
        check("reset", "first_lane", 32'(out_first_lane), 32'd2);
        check("reset3", "valid", 32'(out_valid3), 32'd0);
        check("reset3", "first_lane", 32'(out_first_lane3), 32'd2);
        rst = 1'b0;
        tick();

        // Held pattern: only lane 2 high, which is captured first.
        for (int k = 0; k < 4; k++) yseq[k] = 4'b0100;
        scan(1'b0, 1'b0, 1'b0, "fixed", w);
        check("fixed", "word_const", 32'(out_word), 32'h1);
        handshake(1'b0, 2, w, "fixed");

        // Live sampling: lane_y changes on every capture edge.
        yseq[0] = 4'b1111;
        yseq[1] = 4'b0000;
        yseq[2] = 4'b1111;
        yseq[3] = 4'b0000;
        scan(1'b0, 1'b0, 1'b0, "live", w);
        check("live", "word_const", 32'(out_word), 32'h5);
        handshake(1'b0, 0, w, "live");

        repeat (8) begin
            for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
            scan(1'b0, 1'b0, 1'b1, "rand", w);
            handshake(1'b0, int'($urandom_range(0, 3)), w, "rand");
        end

        // Reset two edges into a scan clears state without waiting for a clock edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        lane_y = 4'($urandom);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst", "busy", 32'(busy), 32'd0);
        check("midrst", "valid", 32'(out_valid), 32'd0);
        check("midrst", "drop_cnt", 32'(drop_cnt), 32'd0);
        check("midrst", "word", 32'(out_word), 32'd0);
        tick();
        rst = 1'b0;
        exp_drop = 0;
        exp_drop3 = 0;
        repeat (3) begin
            tick();
            check("midrst", "valid_after_release", 32'(out_valid), 32'd0);
            check("midrst", "busy_after_release", 32'(busy), 32'd0);
        end
        for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
        scan(1'b0, 1'b0, 1'b0, "post_rst", w);
        handshake(1'b0, 1, w, "post_rst");

        // Back-pressure with three ignored starts, then handshake and start on the same edge.
        for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
        scan(1'b0, 1'b0, 1'b0, "bp", w);
        for (int c = 0; c < 10; c++) begin
            start = (c == 1 || c == 4 || c == 7);
            if (start) exp_drop = sat(exp_drop + 1);
            tick();
            start = 1'b0;
            check("bp", "hold_valid", 32'(out_valid), 32'd1);
            check("bp", "hold_word", 32'(out_word), 32'(w));
        end
        check("bp", "drop_model", 32'(drop_cnt), 32'(exp_drop));
        check("bp", "drop_three", 32'(drop_cnt), 32'd3);
        for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("bp_restart", "valid", 32'(out_valid), 32'd0);
        check("bp_restart", "drop_cnt", 32'(drop_cnt), 32'd3);
        scan(1'b0, 1'b1, 1'b0, "bp_restart", w);
        handshake(1'b0, 0, w, "bp_restart");

        // Three lanes from lane 2: capture order 2, 0, 1.
        for (int k = 0; k < 4; k++) yseq[k] = 4'b0001;
        scan(1'b1, 1'b0, 1'b0, "odd", w);
        check("odd", "word_const", 32'(out_word3), 32'h2);
        handshake(1'b1, 1, w, "odd");
        repeat (5) begin
            for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
            scan(1'b1, 1'b0, 1'b1, "odd_rand", w);
            handshake(1'b1, int'($urandom_range(0, 2)), w, "odd_rand");
        end

        // Saturation: 300 ignored starts while held in VALID.
        for (int k = 0; k < 4; k++) yseq[k] = 4'($urandom);
        scan(1'b0, 1'b0, 1'b0, "sat", w);
        start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            exp_drop = sat(exp_drop + 1);
        end
        start = 1'b0;
        check("sat", "drop_model", 32'(drop_cnt), 32'(exp_drop));
        check("sat", "drop_255", 32'(drop_cnt), 32'd255);
        check("sat", "word", 32'(out_word), 32'(w));
        handshake(1'b0, 0, w, "sat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
